// File: rtl/pulse_burst.sv
// rtl/pulse_burst.sv - rising-edge triggered burst of num pulses, hi cycles high, lo cycles low (optional PULSE_BURST_RETRIG_EN)
module pulse_burst #(
   parameter int width  = 8,
   parameter int cwidth = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [cwidth-1:0] num,
   input  logic [width-1:0]  hi,
   input  logic [width-1:0]  lo,
   output logic              pulse_o,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_start_d;
   logic [cwidth-1:0]   r_num, w_num_nxt;
   logic [cwidth-1:0]   r_cnt, w_cnt_nxt;
   logic [width-1:0]    r_hi, w_hi_nxt;
   logic [width-1:0]    r_lo, w_lo_nxt;
   logic [width-1:0]    r_phase, w_phase_nxt;
   logic                r_pulse, w_pulse_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                w_trig;
   logic [width-1:0]    w_hi_eff;
   logic [width-1:0]    w_lo_eff;

   assign w_trig   = start & ~r_start_d;
   // zero-length phases are stretched to the one-cycle minimum at latch time
   assign w_hi_eff = (hi == '0) ? width'(1) : hi;
   assign w_lo_eff = (lo == '0) ? width'(1) : lo;

   assign pulse_o = r_pulse;
   assign busy    = r_busy;
   assign done    = r_done;

   // state, latched parameters, counters and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_start_d <= 1'b0;
         r_num     <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_phase   <= '0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_start_d <= start;
         r_num     <= w_num_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_phase   <= w_phase_nxt;
         r_pulse   <= w_pulse_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // next-state: phase counter reloads at every phase change, burst counter counts issued pulses
   always_comb begin
      w_state_nxt = r_state;
      w_num_nxt   = r_num;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_phase_nxt = r_phase;
      w_pulse_nxt = r_pulse;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_trig) begin
               if (num != '0) begin
                  w_num_nxt   = num;
                  w_hi_nxt    = w_hi_eff;
                  w_lo_nxt    = w_lo_eff;
                  w_cnt_nxt   = cwidth'(1);
                  w_phase_nxt = '0;
                  w_pulse_nxt = 1'b1;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = HIGH;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end
         end
         HIGH: begin
            if (r_phase == r_hi - width'(1)) begin
               w_phase_nxt = '0;
               w_pulse_nxt = 1'b0;
               if (r_cnt == r_num) begin
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = LOW;
               end
            end else begin
               w_phase_nxt = r_phase + width'(1);
            end
         end
         LOW: begin
            if (r_phase == r_lo - width'(1)) begin
               w_phase_nxt = '0;
               w_pulse_nxt = 1'b1;
               w_cnt_nxt   = r_cnt + cwidth'(1);
               w_state_nxt = HIGH;
            end else begin
               w_phase_nxt = r_phase + width'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_pulse_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase

`ifdef PULSE_BURST_RETRIG_EN
      // a trigger during a burst (completion edge included) restarts it; num==0 ends it instead
      if (w_trig && (r_state != IDLE)) begin
         if (num != '0) begin
            w_num_nxt   = num;
            w_hi_nxt    = w_hi_eff;
            w_lo_nxt    = w_lo_eff;
            w_cnt_nxt   = cwidth'(1);
            w_phase_nxt = '0;
            w_pulse_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_state_nxt = HIGH;
         end else begin
            w_phase_nxt = '0;
            w_pulse_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end
      end
`endif
   end

endmodule
